// File: rtl/seg_pkg.sv
// Shared constants for the two-digit seven-segment scanner.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam logic [1:0] DIG_LO_N = 2'b10;
    localparam logic [1:0] DIG_HI_N = 2'b01;
    localparam logic [1:0] DIG_NONE = 2'b11;

    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

    localparam logic PHASE_ON  = 1'b1;
    localparam logic PHASE_OFF = 1'b0;

    typedef struct packed {
        logic [3:0] hi;
        logic [3:0] lo;
        logic       blink;
    } disp_val_t;

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to seven-segment pattern.
// Codes 10-15 show a dash so bad data is visible.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure lookup; no state.
    always_comb begin
        seg = SEG_DASH;
        unique case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed seven-segment scanner with guard cycles,
// frame-aligned updates, leading-zero blanking and blinking.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 2
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       LOAD,
    input  logic [3:0] DIG_HI,
    input  logic [3:0] DIG_LO,
    input  logic       BLINK,
    input  logic       LZB,
    output logic       PENDING,
    output logic [6:0] DISP,
    output logic [1:0] DISP_D
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;
    logic [FW-1:0] frm_q, frm_d;
    logic          phase_q, phase_d;
    disp_val_t     pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    disp_val_t     act_q, act_d;
    logic          valid_q, valid_d;
    logic [6:0]    disp_q, disp_d;
    logic [1:0]    dsel_q, dsel_d;

    logic          slot_end;
    logic          boundary;
    logic [3:0]    digit;
    logic [6:0]    seg;
    logic          blank;

    bcd_to_seg u_dec (
        .bcd (digit),
        .seg (seg)
    );

    // Slot/frame timing, capture, frame-aligned transfer and blink phase.
    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        boundary = slot_end && (sel_q == SEL_HI);

        cnt_d = slot_end ? '0 : cnt_q + CW'(1);
        sel_d = slot_end ? ~sel_q : sel_q;

        pend_d   = pend_q;
        pend_v_d = pend_v_q && !boundary;
        if (LOAD) begin
            pend_d.hi    = DIG_HI;
            pend_d.lo    = DIG_LO;
            pend_d.blink = BLINK;
            pend_v_d     = 1'b1;
        end

        act_d   = act_q;
        valid_d = valid_q;
        frm_d   = frm_q;
        phase_d = phase_q;
        if (boundary) begin
            if (pend_v_q) begin
                act_d   = pend_q;
                valid_d = 1'b1;
            end
            if (pend_v_q && pend_q.blink) begin
                frm_d   = '0;
                phase_d = PHASE_ON;
            end else if (frm_q == FRM_LAST) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + FW'(1);
            end
        end
    end

    // Next output pattern for the slot currently being scanned.
    always_comb begin
        digit = (sel_q == SEL_HI) ? act_q.hi : act_q.lo;
        blank = !valid_q
             || (cnt_q == '0)
             || (act_q.blink && (phase_q == PHASE_OFF))
             || ((sel_q == SEL_HI) && LZB && (act_q.hi == 4'd0));
        disp_d = blank ? SEG_OFF : seg;
        if (blank)
            dsel_d = DIG_NONE;
        else
            dsel_d = (sel_q == SEL_HI) ? DIG_HI_N : DIG_LO_N;
    end

    // All state, cleared asynchronously including the pending value.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            cnt_q    <= '0;
            sel_q    <= SEL_LO;
            frm_q    <= '0;
            phase_q  <= PHASE_ON;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            act_q    <= '0;
            valid_q  <= 1'b0;
            disp_q   <= SEG_OFF;
            dsel_q   <= DIG_NONE;
        end else begin
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            frm_q    <= frm_d;
            phase_q  <= phase_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            act_q    <= act_d;
            valid_q  <= valid_d;
            disp_q   <= disp_d;
            dsel_q   <= dsel_d;
        end
    end

    assign PENDING = pend_v_q;
    assign DISP    = disp_q;
    assign DISP_D  = dsel_q;

endmodule
